rom_boot_loader: RTL and testbench
==================================

# rom_boot_loader

Boot sequencer for the program ROM. After reset, or on a `start` pulse, it copies a fixed window of program words out of the ROM into RAM, one word at a time. During the copy it enables the ROM's tri-state data drive and holds the CPU in reset; the CPU is released only after the last word has been written. It sits between `rom`, the RAM write port and the CPU reset input.

## Interface
Parameters:
- `ADDR_SIZE`, default `` `ADDR_SIZE `` — width of ROM/RAM addresses.
- `WORD_SIZE`, default `` `WORD_SIZE `` — width of one instruction/data word.
- `BOOT_LEN`, default 22 — number of address units to copy. Copied addresses are 0 to BOOT_LEN-ADDR_STEP. Must be a nonzero multiple of ADDR_STEP and ≤ 2^ADDR_SIZE.
- `ADDR_STEP`, default 2 — address increment per word.
- `TIMEOUT`, default 16 — maximum cycles one RAM write may wait for `ram_ready`; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin/restart the copy; sampled only in IDLE, DONE or ERROR.
- `rom_boot`  out  1  ROM output enable (drives the ROM's `boot` input).
- `rom_addr`  out  ADDR_SIZE  ROM read address.
- `rom_data`  in  WORD_SIZE  ROM data bus (read only here).
- `ram_addr`  out  ADDR_SIZE  RAM write address.
- `ram_wdata`  out  WORD_SIZE  RAM write data.
- `ram_wr_en`  out  1  RAM write request.
- `ram_ready`  in  1  RAM accepts the write this cycle when high with `ram_wr_en`.
- `busy`  out  1  copy in progress.
- `done`  out  1  copy completed successfully.
- `error`  out  1  copy aborted on timeout.
- `cpu_hold`  out  1  active-high hold-in-reset for the CPU.

## Operation
- Reset values:
  - All outputs are 0 except `cpu_hold`=1.
  - State is IDLE and the address counter is 0.
- IDLE → FETCH when `start`=1. The address counter is cleared to 0 on entry.
- FETCH (one cycle):
  - `rom_boot`=1 and `rom_addr`=counter.
  - `rom_data` is registered into `ram_wdata` at the end of the cycle.
  - Counter is copied to `ram_addr`.
  - Next state is WRITE.
- WRITE:
  - `rom_boot`=1 and `ram_wr_en`=1; `ram_addr` and `ram_wdata` stay stable.
  - The write completes on the cycle where `ram_ready`=1.
  - After completion: if counter = BOOT_LEN-ADDR_STEP → DONE; otherwise counter += ADDR_STEP → FETCH.
- Timeout:
  - A wait counter clears on WRITE entry and increments on each WRITE cycle with `ram_ready`=0.
  - If it reaches TIMEOUT, the next state is ERROR. `ram_ready` on that same cycle still completes the write, so completion wins.
- DONE:
  - `done`=1, `cpu_hold`=0, `rom_boot`=0, `busy`=0.
  - `start` → FETCH from address 0, with `done` cleared and `cpu_hold`=1.
- ERROR:
  - `error`=1, `cpu_hold`=1, `ram_wr_en`=0.
  - `start` → FETCH from address 0, with `error` cleared.
- `busy`=1 exactly in FETCH and WRITE. `start` is ignored while busy.
- The address counter is ADDR_SIZE bits wide and never wraps: the termination compare fires before overflow.
- Reset mid-copy: everything returns to reset values immediately (asynchronously). `ram_wr_en` drops without a handshake.

## Timing
- `start` sampled high at edge k puts the block in FETCH during cycle k+1 and WRITE during cycle k+2.
- With `ram_ready` held at 1, each word takes 2 cycles. For N = BOOT_LEN/ADDR_STEP words:
  - the last write completes in cycle k+2N;
  - `done` and `cpu_hold`=0 appear in cycle k+2N+1.
- Each cycle `ram_ready` is held low adds one cycle to that word.
- ERROR is entered on the cycle after the TIMEOUT-th consecutive not-ready WRITE cycle.
- `rom_boot` is high from the first FETCH through the last WRITE, continuously. It does not drop between words.

## Test plan
- **Default parameters, `ram_ready` tied to 1, `start` at cycle 0:**
  - RAM receives 11 writes at addresses 0, 2, …, 20.
  - Word at address 18 = 16'h8000; word at address 20 = 16'h0001.
  - `done` rises in cycle 23.
- **`ram_ready` low for 3 cycles on the write to address 4:**
  - `ram_wr_en`, `ram_addr`=4 and `ram_wdata` stay stable throughout the wait.
  - Total completion is 3 cycles later than the first scenario.
- **TIMEOUT=4, `ram_ready` stuck at 0:**
  - ERROR is entered after 4 WRITE cycles; `error`=1, `cpu_hold`=1, `ram_wr_en`=0.
  - A later `start` with `ram_ready`=1 completes the copy normally.
- **`start` pulsed while busy:** ignored; no address restart.
- **Re-`start` from DONE:** `cpu_hold` reasserts and the copy restarts at address 0.
- **`rst_n` asserted during WRITE to address 8:** all outputs go to reset values in the same cycle, with no further RAM writes.

Source files
------------

// File: rtl/rom_boot_loader.sv
// rtl/rom_boot_loader.sv - ROM-to-RAM boot copy sequencer with CPU reset hold
//
// Copies ROM addresses 0 .. BOOT_LEN-ADDR_STEP into RAM, one word per
// FETCH/WRITE pair, holding the CPU in reset until the last write lands.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin/restart a copy (honoured in IDLE, DONE, ERROR)
//   rom_boot          ROM output enable, high for the whole copy
//   rom_addr          ROM read address (the copy counter)
//   rom_data          ROM data bus, captured during FETCH
//   ram_addr          RAM write address
//   ram_wdata         RAM write data
//   ram_wr_en         RAM write request, held until ram_ready
//   ram_ready         RAM accepts the write when high with ram_wr_en
//   busy              copy in progress (FETCH or WRITE)
//   done              copy finished successfully
//   error             copy aborted because a write timed out
//   cpu_hold          active-high CPU reset hold
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module rom_boot_loader #(
  parameter int ADDR_SIZE = `ADDR_SIZE,
  parameter int WORD_SIZE = `WORD_SIZE,
  parameter int BOOT_LEN  = 22,
  parameter int ADDR_STEP = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 rom_boot,
  output logic [ADDR_SIZE-1:0] rom_addr,
  input  logic [WORD_SIZE-1:0] rom_data,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_wdata,
  output logic                 ram_wr_en,
  input  logic                 ram_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR  = ADDR_SIZE'(BOOT_LEN - ADDR_STEP);
  localparam logic [ADDR_SIZE-1:0] STEP       = ADDR_SIZE'(ADDR_STEP);
  // Error is decided on the TIMEOUT-th not-ready cycle itself, so compare
  // against the count of earlier not-ready cycles.
  localparam logic [WAIT_W-1:0]    WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] cnt_q, cnt_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [ADDR_SIZE-1:0] ram_addr_q;
  logic [WORD_SIZE-1:0] ram_wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wait_q      <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      if (state_q == S_FETCH) begin
        ram_addr_q  <= cnt_q;
        ram_wdata_q <= rom_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        state_d = S_WRITE;
        wait_d  = '0;
      end
      S_WRITE: begin
        // A write accepted on the last allowed cycle still completes.
        if (ram_ready) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + STEP;
            state_d = S_FETCH;
          end
        end else if (wait_q == WAIT_LIMIT) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rom_boot  = 1'b0;
    ram_wr_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_hold  = 1'b1;
    case (state_q)
      S_FETCH: begin
        rom_boot = 1'b1;
        busy     = 1'b1;
      end
      S_WRITE: begin
        rom_boot  = 1'b1;
        ram_wr_en = 1'b1;
        busy      = 1'b1;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  assign rom_addr  = cnt_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_rom_boot_loader.sv
// tb/tb_rom_boot_loader.sv - self-checking bench for rom_boot_loader
module tb_rom_boot_loader;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int BOOT_LEN = 22;
  localparam int STEP = 2;
  localparam int TMO = 4;
  localparam int NWORDS = BOOT_LEN / STEP;
  localparam int LIMIT = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          rom_boot;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wr_en;
  logic          ram_ready = 1'b1;
  logic          busy, done, error, cpu_hold;

  rom_boot_loader #(
    .ADDR_SIZE(AW), .WORD_SIZE(DW), .BOOT_LEN(BOOT_LEN),
    .ADDR_STEP(STEP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_boot(rom_boot), .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wr_en(ram_wr_en),
    .ram_ready(ram_ready), .busy(busy), .done(done), .error(error),
    .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    case (a)
      16'd18:  rom_word = 16'h8000;
      16'd20:  rom_word = 16'h0001;
      default: rom_word = (a * 16'h0137) ^ 16'hA5C3;
    endcase
  endfunction

  assign rom_data = rom_boot ? rom_word(rom_addr) : '0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    logic [AW-1:0] stall_addr;
    int            stall_n;
    int            pulse_c;
    int            exp_end;
    logic          exp_done;
  } vec_t;

  int passed = 0;
  int total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_copy(input vec_t v, input int idx);
    int   end_c = 0;
    int   stalled = 0;
    logic boot_drop = 1'b0;
    wr_t  w;
    for (int i = 0; i < NWORDS; i++) begin
      w.addr = AW'(i * STEP);
      w.data = rom_word(w.addr);
      sb.push_back(w);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= LIMIT; c++) begin
      if (done || error) begin
        end_c = c;
        break;
      end
      if (c == 1) begin
        chk($sformatf("v%0d_first_hold", idx), {cpu_hold, done, error, busy}, 4'b1001);
      end
      if (!rom_boot) boot_drop = 1'b1;
      ram_ready = 1'b1;
      if (ram_wr_en && ram_addr == v.stall_addr && stalled < v.stall_n) begin
        ram_ready = 1'b0;
        stalled++;
        chk($sformatf("v%0d_stall_stable", idx), {ram_addr, ram_wdata},
            {v.stall_addr, rom_word(v.stall_addr)});
      end
      if (ram_wr_en && ram_ready) begin
        if (sb.size() == 0) begin
          chk($sformatf("v%0d_extra_write", idx), {ram_addr, ram_wdata}, 32'hFFFF_FFFF);
        end else begin
          w = sb.pop_front();
          chk($sformatf("v%0d_write", idx), {ram_addr, ram_wdata}, {w.addr, w.data});
        end
      end
      start = (c == v.pulse_c);
      tick();
    end
    start = 1'b0;
    ram_ready = 1'b1;
    chk($sformatf("v%0d_end_cycle", idx), end_c, v.exp_end);
    chk($sformatf("v%0d_status", idx), {done, error, cpu_hold, busy, ram_wr_en, rom_boot},
        {v.exp_done, !v.exp_done, !v.exp_done, 3'b000});
    chk($sformatf("v%0d_boot_held", idx), boot_drop, 1'b0);
    if (v.exp_done) chk($sformatf("v%0d_sb_empty", idx), sb.size(), 0);
    sb.delete();
    tick();
  endtask

  vec_t vecs[8];
  logic wr_seen;

  initial begin
    vecs[0] = '{16'hFFFF, 0,   0, 23, 1'b1};  // plain copy, ready tied high
    vecs[1] = '{16'd4,    3,   0, 26, 1'b1};  // 3-cycle stall at address 4
    vecs[2] = '{16'hFFFF, 0,   5, 23, 1'b1};  // start pulsed while busy
    vecs[3] = '{16'd20,   3,   0, 26, 1'b1};  // stall one short of timeout on last word
    vecs[4] = '{16'd10,   4,   0, 16, 1'b0};  // exactly TIMEOUT not-ready cycles
    vecs[5] = '{16'hFFFF, 0,   0, 23, 1'b1};  // restart from ERROR
    vecs[6] = '{16'd0,    100, 0, 6,  1'b0};  // ready stuck low
    vecs[7] = '{16'hFFFF, 0,   0, 23, 1'b1};  // restart from ERROR again

    #2;
    chk("reset_outputs", {rom_boot, rom_addr, ram_addr, ram_wdata, ram_wr_en, busy, done, error, cpu_hold},
        {1'b0, 16'h0, 16'h0, 16'h0, 5'b00001});
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_quiet", {busy, done, error, cpu_hold}, 4'b0001);

    for (int i = 0; i < 8; i++) run_copy(vecs[i], i);

    // Reset asserted while writing address 8.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    chk("pre_reset_write8", {ram_wr_en, ram_addr}, {1'b1, 16'd8});
    rst_n = 1'b0;
    #1;
    chk("midcopy_reset_outputs",
        {rom_boot, rom_addr, ram_addr, ram_wdata, ram_wr_en, busy, done, error, cpu_hold},
        {1'b0, 16'h0, 16'h0, 16'h0, 5'b00001});
    wr_seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ram_wr_en) wr_seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (ram_wr_en) wr_seen = 1'b1;
    end
    chk("no_write_after_reset", wr_seen, 1'b0);
    run_copy(vecs[0], 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
